// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
//
// Single-entry ID/EX pipeline register in front of the RV32I ALU. It resolves
// both source operands by forwarding from EX/MEM and WB, picks the immediate
// for operand b, and holds off any instruction that reads the destination of
// a load still sitting in EX/MEM. The stall must last exactly one cycle,
// because on the next cycle the load value arrives on the WB bypass.
//
// Handshake: valid/ready on both sides. A transfer happens on a rising edge
// where valid & ready are both high. valid never depends on ready. in_ready is
// the only combinational output. It is a function of out_valid, out_ready,
// the hazard and flush.
//
// Ports
//   clk, rst_n                          clock, async active-low reset
//   in_valid / in_ready                 decoded-instruction handshake
//   in_rs1, in_rs2, in_rs*_used         source indices, and whether each is read
//   in_rs1_data, in_rs2_data            register-file read data
//   in_rd, in_aluop, in_use_imm, in_imm destination, ALU op, immediate select
//   in_is_load                          instruction is a load
//   flush                               squash on branch redirect
//   exm_valid/exm_is_load/exm_rd/exm_result   EX/MEM bypass source
//   wb_valid/wb_rd/wb_data              WB bypass source
//   out_valid / out_ready               handshake to the ALU stage
//   out_aluop, out_a, out_b, out_rs2_val, out_rd, out_is_load  registered payload
//   stall_cnt                           saturating count of load-use stall cycles
//
// The EMPTY/FULL state is the out_valid output itself.
module id_ex_operand_stage #(
  parameter int XLEN        = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4:0]             in_rs1,
  input  logic [4:0]             in_rs2,
  input  logic                   in_rs1_used,
  input  logic                   in_rs2_used,
  input  logic [XLEN-1:0]        in_rs1_data,
  input  logic [XLEN-1:0]        in_rs2_data,
  input  logic [4:0]             in_rd,
  input  logic [2:0]             in_aluop,
  input  logic                   in_use_imm,
  input  logic [XLEN-1:0]        in_imm,
  input  logic                   in_is_load,
  input  logic                   flush,
  input  logic                   exm_valid,
  input  logic                   exm_is_load,
  input  logic [4:0]             exm_rd,
  input  logic [XLEN-1:0]        exm_result,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_rd,
  input  logic [XLEN-1:0]        wb_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2:0]             out_aluop,
  output logic [XLEN-1:0]        out_a,
  output logic [XLEN-1:0]        out_b,
  output logic [XLEN-1:0]        out_rs2_val,
  output logic [4:0]             out_rd,
  output logic                   out_is_load,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t state;

  logic            hazard;
  logic            capture;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  // An EX/MEM load has no result yet, so it is never a bypass source.
  // x0 is never forwarded, so a zero index always passes the register-file value.
  function automatic logic [XLEN-1:0] resolve(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] rf_data,
    input logic            e_valid,
    input logic            e_is_load,
    input logic [4:0]      e_rd,
    input logic [XLEN-1:0] e_result,
    input logic            w_valid,
    input logic [4:0]      w_rd,
    input logic [XLEN-1:0] w_data
  );
    logic [XLEN-1:0] v;
    v = rf_data;
    if (rs != 5'd0) begin
      if (e_valid && !e_is_load && e_rd == rs)
        v = e_result;
      else if (w_valid && w_rd == rs)
        v = w_data;
    end
    return v;
  endfunction

  always_comb begin
    rs1_val = resolve(in_rs1, in_rs1_data, exm_valid, exm_is_load, exm_rd,
                      exm_result, wb_valid, wb_rd, wb_data);
    rs2_val = resolve(in_rs2, in_rs2_data, exm_valid, exm_is_load, exm_rd,
                      exm_result, wb_valid, wb_rd, wb_data);
  end

  assign hazard = in_valid & exm_valid & exm_is_load & (exm_rd != 5'd0) &
                  ((in_rs1_used & (exm_rd == in_rs1)) |
                   (in_rs2_used & (exm_rd == in_rs2)));

  // flush blocks capture here, so a squashed cycle can never load the register.
  assign in_ready  = (!out_valid | out_ready) & !hazard & !flush;
  assign capture   = in_valid & in_ready;
  assign out_valid = (state == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      out_aluop   <= '0;
      out_a       <= '0;
      out_b       <= '0;
      out_rs2_val <= '0;
      out_rd      <= '0;
      out_is_load <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      case (state)
        EMPTY: if (capture) state <= FULL;
        FULL:  if (!capture && (out_ready || flush)) state <= EMPTY;
        default: state <= EMPTY;
      endcase

      // Payload changes only on capture. While empty, its contents are don't-care.
      if (capture) begin
        out_aluop   <= in_aluop;
        out_a       <= rs1_val;
        out_b       <= in_use_imm ? in_imm : rs2_val;
        out_rs2_val <= rs2_val;
        out_rd      <= in_rd;
        out_is_load <= in_is_load;
      end

      // A flushed cycle is not a real stall, so flush suppresses the count.
      if (hazard && !flush && stall_cnt != {STALL_CNT_W{1'b1}})
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;

  localparam int XLEN = 32;
  localparam int SCW  = 16;
  localparam int W    = 3 * XLEN + 9;  // {aluop, a, b, rs2_val, rd, is_load}
  localparam int SAT  = (1 << SCW) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, in_ready;
  logic [4:0]      in_rs1, in_rs2, in_rd;
  logic            in_rs1_used, in_rs2_used;
  logic [XLEN-1:0] in_rs1_data, in_rs2_data, in_imm;
  logic [2:0]      in_aluop;
  logic            in_use_imm, in_is_load, flush;
  logic            exm_valid, exm_is_load;
  logic [4:0]      exm_rd;
  logic [XLEN-1:0] exm_result;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            out_valid, out_ready;
  logic [2:0]      out_aluop;
  logic [XLEN-1:0] out_a, out_b, out_rs2_val;
  logic [4:0]      out_rd;
  logic            out_is_load;
  logic [SCW-1:0]  stall_cnt;

  id_ex_operand_stage #(.XLEN(XLEN), .STALL_CNT_W(SCW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_rd(in_rd), .in_aluop(in_aluop), .in_use_imm(in_use_imm),
    .in_imm(in_imm), .in_is_load(in_is_load), .flush(flush),
    .exm_valid(exm_valid), .exm_is_load(exm_is_load),
    .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_aluop(out_aluop), .out_a(out_a), .out_b(out_b),
    .out_rs2_val(out_rs2_val), .out_rd(out_rd),
    .out_is_load(out_is_load), .stall_cnt(stall_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];   // at most one entry: what the ALU should be seeing
  int           m_stalls;   // unbounded count of stall cycles
  int           n_checks;
  int           n_fail;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [XLEN-1:0] ref_operand(input logic [4:0] rs, input logic [XLEN-1:0] rf);
    if (rs == 0) return rf;
    if (exm_valid && !exm_is_load && exm_rd == rs) return exm_result;
    if (wb_valid && wb_rd == rs) return wb_data;
    return rf;
  endfunction

  function automatic bit ref_hazard();
    bit hit1, hit2;
    hit1 = in_rs1_used && (in_rs1 == exm_rd);
    hit2 = in_rs2_used && (in_rs2 == exm_rd);
    return in_valid && exm_valid && exm_is_load && exm_rd != 0 && (hit1 || hit2);
  endfunction

  function automatic bit ref_ready();
    return (exp_q.size() == 0 || out_ready) && !ref_hazard() && !flush;
  endfunction

  function automatic logic [W-1:0] ref_entry();
    logic [XLEN-1:0] a, r2;
    a  = ref_operand(in_rs1, in_rs1_data);
    r2 = ref_operand(in_rs2, in_rs2_data);
    return {in_aluop, a, (in_use_imm ? in_imm : r2), r2, in_rd, in_is_load};
  endfunction

  // Applied at each rising edge, using the inputs that were driven for that cycle.
  task automatic model_edge();
    bit take;
    take = in_valid && ref_ready();
    if (ref_hazard() && !flush) m_stalls++;
    if (take) begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      exp_q.push_back(ref_entry());
    end else if (exp_q.size() != 0 && (out_ready || flush)) begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic check_outputs();
    logic [W-1:0] e;
    check("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      check("out_aluop",   out_aluop,   e[104:102]);
      check("out_a",       out_a,       e[101:70]);
      check("out_b",       out_b,       e[69:38]);
      check("out_rs2_val", out_rs2_val, e[37:6]);
      check("out_rd",      out_rd,      e[5:1]);
      check("out_is_load", out_is_load, e[0]);
    end
    check("stall_cnt", stall_cnt, (m_stalls > SAT) ? SAT : m_stalls);
  endtask

  // One clock: inputs are already driven (at the falling edge).
  task automatic step();
    #1;
    check("in_ready", in_ready, ref_ready());
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rs1_used = 0; in_rs2_used = 0;
    in_rs1_data = 0; in_rs2_data = 0; in_rd = 0; in_aluop = 0; in_use_imm = 0;
    in_imm = 0; in_is_load = 0; flush = 0;
    exm_valid = 0; exm_is_load = 0; exm_rd = 0; exm_result = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0; out_ready = 1;
  endtask

  task automatic drive_random();
    in_valid    = ($urandom_range(0, 9) < 8);
    in_rs1      = 5'($urandom_range(0, 7));
    in_rs2      = 5'($urandom_range(0, 7));
    in_rs1_used = $urandom_range(0, 1);
    in_rs2_used = $urandom_range(0, 1);
    in_rs1_data = (in_rs1 == 0) ? 0 : $urandom;
    in_rs2_data = (in_rs2 == 0) ? 0 : $urandom;
    in_rd       = 5'($urandom_range(0, 31));
    in_aluop    = 3'($urandom_range(0, 7));
    in_use_imm  = $urandom_range(0, 1);
    in_imm      = $urandom;
    in_is_load  = $urandom_range(0, 1);
    flush       = ($urandom_range(0, 9) == 0);
    exm_valid   = $urandom_range(0, 1);
    exm_is_load = ($urandom_range(0, 3) == 0);
    exm_rd      = 5'($urandom_range(0, 7));
    exm_result  = $urandom;
    wb_valid    = $urandom_range(0, 1);
    wb_rd       = 5'($urandom_range(0, 7));
    wb_data     = $urandom;
    out_ready   = ($urandom_range(0, 9) < 7);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_aluop"}, out_aluop, 0);
    check({tag, "_a"}, out_a, 0);
    check({tag, "_b"}, out_b, 0);
    check({tag, "_rs2_val"}, out_rs2_val, 0);
    check({tag, "_rd"}, out_rd, 0);
    check({tag, "_is_load"}, out_is_load, 0);
    check({tag, "_stall_cnt"}, stall_cnt, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    n_checks = 0; n_fail = 0; m_stalls = 0;
    rst_n = 0;
    drive_idle();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1;

    // EX/MEM forward onto rs1
    in_valid = 1; in_rs1 = 5; in_rs1_used = 1; in_rs1_data = 32'hDEAD;
    exm_valid = 1; exm_rd = 5; exm_result = 32'h1234;
    step();
    check("fwd_exm_a", out_a, 32'h1234);
    check("fwd_exm_valid", out_valid, 1);

    // EX/MEM beats WB on the same register
    drive_idle();
    in_valid = 1; in_rs2 = 7; in_rs2_used = 1; in_rs2_data = 32'h3333;
    exm_valid = 1; exm_rd = 7; exm_result = 32'h1111;
    wb_valid = 1; wb_rd = 7; wb_data = 32'h2222;
    step();
    check("fwd_prio_b", out_b, 32'h1111);

    // x0 is never forwarded
    drive_idle();
    in_valid = 1; in_rs1 = 0; in_rs1_used = 1;
    exm_valid = 1; exm_rd = 0; exm_result = 32'hFFFF;
    step();
    check("x0_a", out_a, 0);

    // load-use: one stall cycle, then WB bypass supplies the value
    drive_idle();
    in_valid = 1; in_rs2 = 3; in_rs2_used = 1; in_rs2_data = 32'h77;
    exm_valid = 1; exm_is_load = 1; exm_rd = 3;
    #1 check("lu_in_ready", in_ready, 0);
    step();
    check("lu_stall_cnt", stall_cnt, 1);
    check("lu_bubble", out_valid, 0);
    exm_valid = 0; exm_is_load = 0;
    wb_valid = 1; wb_rd = 3; wb_data = 32'hAA;
    step();
    check("lu_b", out_b, 32'hAA);
    check("lu_valid", out_valid, 1);

    // backpressure: entry holds for three cycles, then the next one captures
    drive_idle();
    in_valid = 1; in_aluop = 3; in_rs1 = 1; in_rs1_used = 1; in_rs1_data = 32'h11111111;
    step();
    out_ready = 0; in_rs1_data = 32'h55555555; in_aluop = 5;
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_in_ready", in_ready, 0);
      step();
      check("bp_hold_a", out_a, 32'h11111111);
      check("bp_hold_op", out_aluop, 3);
    end
    out_ready = 1;
    step();
    check("bp_resume_a", out_a, 32'h55555555);

    // flush with a full stage and a waiting instruction
    out_ready = 0; flush = 1;
    step();
    check("flush_valid", out_valid, 0);
    flush = 0;

    // reset in the middle of a stall
    drive_idle();
    in_valid = 1; in_rs1 = 4; in_rs1_used = 1; in_rs1_data = 32'hCAFE; in_rd = 9;
    step();
    out_ready = 0; exm_valid = 1; exm_is_load = 1; exm_rd = 4;
    step();
    #2 rst_n = 0;
    #1 check_all_zero("midrst");
    exp_q.delete(); m_stalls = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    drive_idle();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive_random();
      step();
    end

    // saturation of the stall counter
    drive_idle();
    in_valid = 1; in_rs1 = 2; in_rs1_used = 1;
    exm_valid = 1; exm_is_load = 1; exm_rd = 2;
    for (int i = 0; i < SAT + 4; i++) step();
    check("sat_stall_cnt", stall_cnt, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
